// File: rtl/conv_layer.sv
// conv_layer: valid (no-padding), stride-1 multi-channel 2-D convolution over external memories.
// Latency: OUT_CH*(2+OUT*OUT*(N+2))+1 cycles from accepted start to the done pulse.
// No backpressure: the memories respond one cycle after the address, and writes are fire-and-forget.
// Optional macro CONV_LAYER_RELU_EN: clamps negative results to 0 before they are written.
module conv_layer #(
  parameter int DATA_SIZE   = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int IN_CH       = 1,
  parameter int OUT_CH      = 6,
  parameter int K           = 5,
  parameter int FRAC_BITS   = 0,
  parameter int WEIGHT_BASE = 0,
  parameter int BIAS_BASE   = 150,
  parameter int INPUT_BASE  = 0,
  parameter int RESULT_BASE = 0,
  parameter int W_AW        = 8,
  parameter int I_AW        = 10,
  parameter int R_AW        = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 w_en,
  output logic [W_AW-1:0]      w_addr,
  input  logic [DATA_SIZE-1:0] w_dout,
  output logic                 in_en,
  output logic [I_AW-1:0]      in_addr,
  input  logic [DATA_SIZE-1:0] in_dout,
  output logic                 res_we,
  output logic [R_AW-1:0]      res_addr,
  output logic [DATA_SIZE-1:0] res_din
);

  localparam int OUT   = IMAGE_SIZE - K + 1;
  localparam int N     = IN_CH * K * K;
  localparam int ACC_W = 2 * DATA_SIZE + $clog2(N) + 1;
  localparam int TW    = $clog2(N + 1);
  localparam int CW    = $clog2(IN_CH + 1);
  localparam int KW    = $clog2(K + 1);
  localparam int OW    = $clog2(OUT + 1);
  localparam int FW    = $clog2(OUT_CH + 1);

  localparam logic signed [DATA_SIZE-1:0] DMAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] DMIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [FW-1:0]             f_q;
  logic [OW-1:0]             oy_q, ox_q;
  logic [TW-1:0]             tap_q;
  logic [CW-1:0]             c_q;
  logic [KW-1:0]             ky_q, kx_q;
  logic                      bias_ph_q;
  logic [DATA_SIZE-1:0]      bias_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic                      tap_issue;
  logic                      last_px;
  logic                      last_f;
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]   acc_sh;
  logic [DATA_SIZE-1:0]      sat_val;

  // Bias sign-extended to accumulator width and aligned to the fixed-point product scale.
  function automatic logic signed [ACC_W-1:0] bias_ext(input logic [DATA_SIZE-1:0] b);
    return ACC_W'($signed(b)) <<< FRAC_BITS;
  endfunction

  assign tap_issue = (state_q == S_MAC) && (tap_q != TW'(N));
  assign last_px   = (ox_q == OW'(OUT - 1)) && (oy_q == OW'(OUT - 1));
  assign last_f    = (f_q == FW'(OUT_CH - 1));
  assign prod      = $signed(in_dout) * $signed(w_dout);
  assign acc_sh    = acc_q >>> FRAC_BITS;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: bias fetch per filter, one MAC pass plus a write per output pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BIAS;
      S_BIAS:  if (bias_ph_q) state_d = S_MAC;
      S_MAC:   if (tap_q == TW'(N)) state_d = S_WRITE;
      S_WRITE: begin
        if (last_px && last_f) state_d = S_DONE;
        else if (last_px)      state_d = S_BIAS;
        else                   state_d = S_MAC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, bias capture and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q       <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      tap_q     <= '0;
      c_q       <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      bias_ph_q <= 1'b0;
      bias_q    <= '0;
      acc_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f_q       <= '0;
            oy_q      <= '0;
            ox_q      <= '0;
            tap_q     <= '0;
            c_q       <= '0;
            ky_q      <= '0;
            kx_q      <= '0;
            bias_ph_q <= 1'b0;
          end
        end
        S_BIAS: begin
          // Phase 0 issues the bias address, phase 1 sees the read data.
          bias_ph_q <= ~bias_ph_q;
          if (bias_ph_q) begin
            bias_q <= w_dout;
            acc_q  <= bias_ext(w_dout);
            tap_q  <= '0;
            c_q    <= '0;
            ky_q   <= '0;
            kx_q   <= '0;
          end
        end
        S_MAC: begin
          // Data returned now belongs to the tap issued in the previous cycle.
          if (tap_q != '0) acc_q <= acc_q + ACC_W'(prod);
          if (tap_issue) begin
            tap_q <= tap_q + TW'(1);
            if (kx_q == KW'(K - 1)) begin
              kx_q <= '0;
              if (ky_q == KW'(K - 1)) begin
                ky_q <= '0;
                c_q  <= c_q + CW'(1);
              end else begin
                ky_q <= ky_q + KW'(1);
              end
            end else begin
              kx_q <= kx_q + KW'(1);
            end
          end
        end
        S_WRITE: begin
          tap_q <= '0;
          c_q   <= '0;
          ky_q  <= '0;
          kx_q  <= '0;
          acc_q <= bias_ext(bias_q);
          if (ox_q == OW'(OUT - 1)) begin
            ox_q <= '0;
            if (oy_q == OW'(OUT - 1)) begin
              oy_q <= '0;
              f_q  <= f_q + FW'(1);
            end else begin
              oy_q <= oy_q + OW'(1);
            end
          end else begin
            ox_q <= ox_q + OW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturate the rescaled accumulator to the output width, optionally clamping negatives.
  always_comb begin
    sat_val = acc_sh[DATA_SIZE-1:0];
    if (acc_sh > ACC_W'(DMAX))      sat_val = DMAX;
    else if (acc_sh < ACC_W'(DMIN)) sat_val = DMIN;
`ifdef CONV_LAYER_RELU_EN
    if (acc_sh[ACC_W-1]) sat_val = '0;
`else
`endif
  end

  // Outputs: strobes only in cycles that use them, buses held at 0 otherwise.
  always_comb begin
    busy     = (state_q == S_BIAS) || (state_q == S_MAC) || (state_q == S_WRITE);
    done     = (state_q == S_DONE);
    w_en     = 1'b0;
    w_addr   = '0;
    in_en    = 1'b0;
    in_addr  = '0;
    res_we   = 1'b0;
    res_addr = '0;
    res_din  = '0;
    if (state_q == S_BIAS && !bias_ph_q) begin
      w_en   = 1'b1;
      w_addr = W_AW'(BIAS_BASE + 32'(f_q));
    end
    if (tap_issue) begin
      w_en    = 1'b1;
      w_addr  = W_AW'(WEIGHT_BASE + 32'(f_q) * N + 32'(tap_q));
      in_en   = 1'b1;
      in_addr = I_AW'(INPUT_BASE + 32'(c_q) * IMAGE_SIZE * IMAGE_SIZE
                      + (32'(oy_q) + 32'(ky_q)) * IMAGE_SIZE + 32'(ox_q) + 32'(kx_q));
    end
    if (state_q == S_WRITE) begin
      res_we   = 1'b1;
      res_addr = R_AW'(RESULT_BASE + 32'(f_q) * OUT * OUT + 32'(oy_q) * OUT + 32'(ox_q));
      res_din  = sat_val;
    end
  end

endmodule
